// File: rtl/bnn_popcount_acc.sv
// Popcount accumulator for the binarized CNN datapath: sums the ones in BEATS beats of
// DATA_W product bits and hands the window sum plus a thresholded activation downstream.
module bnn_popcount_acc #(
   parameter int DATA_W = 8,
   parameter int BEATS  = 9,
   parameter int ACC_W  = 7,
   parameter int THRESH = 36
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic [DATA_W-1:0] in_bits,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_act,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  beat_cnt
);

   localparam logic [0:0]       S_ACC     = 1'b0;
   localparam logic [0:0]       S_OUT     = 1'b1;
   localparam logic [ACC_W-1:0] LAST_BEAT = ACC_W'(BEATS - 1);
   localparam logic [31:0]      THRESH_U  = 32'(THRESH);

   logic [0:0]       r_state;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_beatCnt;
   logic [ACC_W-1:0] r_outSum;
   logic             r_outAct;

   logic [ACC_W-1:0] w_pop;
   logic [ACC_W-1:0] w_sum;
   logic             w_act;
   logic             w_beatFire;
   logic             w_lastBeat;

   // Beat popcount is folded straight into the running sum so the result lands one cycle after the last beat.
   always_comb begin
      w_pop = '0;
      for (int i = 0; i < DATA_W; i++) begin
         w_pop = w_pop + ACC_W'(in_bits[i]);
      end
   end

   assign w_sum      = r_acc + w_pop;
   assign w_act      = (32'(w_sum) >= THRESH_U);
   assign w_beatFire = in_valid && (r_state == S_ACC);
   assign w_lastBeat = (r_beatCnt == LAST_BEAT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_ACC;
         r_acc     <= '0;
         r_beatCnt <= '0;
         r_outSum  <= '0;
         r_outAct  <= 1'b0;
      end else if (clr) begin
         // Flush drops any coincident beat or transfer but leaves the last published result visible.
         r_state   <= S_ACC;
         r_acc     <= '0;
         r_beatCnt <= '0;
      end else begin
         case (r_state)
            S_ACC: begin
               if (w_beatFire) begin
                  if (w_lastBeat) begin
                     r_outSum  <= w_sum;
                     r_outAct  <= w_act;
                     r_acc     <= '0;
                     r_beatCnt <= '0;
                     r_state   <= S_OUT;
                  end else begin
                     r_acc     <= w_sum;
                     r_beatCnt <= r_beatCnt + 1'b1;
                  end
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  r_state <= S_ACC;
               end
            end
            default: begin
               r_state <= S_ACC;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == S_ACC);
   assign out_valid = (r_state == S_OUT);
   assign out_sum   = r_outSum;
   assign out_act   = r_outAct;
   assign beat_cnt  = r_beatCnt;

endmodule

// File: tb/tb_bnn_popcount_acc.sv
// Self-checking bench for bnn_popcount_acc: directed window scenarios followed by random
// traffic, all compared against a queue-based window model.
module tb_bnn_popcount_acc;

   localparam int DATA_W = 8;
   localparam int BEATS  = 9;
   localparam int ACC_W  = 7;
   localparam int THRESH = 36;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clr = 1'b0;
   logic [DATA_W-1:0] in_bits = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [ACC_W-1:0]  out_sum;
   logic              out_act;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [ACC_W-1:0]  beat_cnt;

   int vectors = 0;
   int miscompares = 0;

   // Model: popcounts of beats accepted in the open window, plus the last published result.
   int window[$];
   bit resultPending = 1'b0;
   int expSum = 0;
   bit expAct = 1'b0;

   bnn_popcount_acc #(
      .DATA_W(DATA_W),
      .BEATS(BEATS),
      .ACC_W(ACC_W),
      .THRESH(THRESH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .clr(clr),
      .in_bits(in_bits),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .out_sum(out_sum),
      .out_act(out_act),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .beat_cnt(beat_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic modelEdge(input bit rstN, input bit clrV, input logic [DATA_W-1:0] bits,
                            input bit valid, input bit oready);
      int s;
      if (!rstN) begin
         window.delete();
         resultPending = 1'b0;
         expSum = 0;
         expAct = 1'b0;
      end else if (clrV) begin
         window.delete();
         resultPending = 1'b0;
      end else if (resultPending) begin
         if (oready) resultPending = 1'b0;
      end else if (valid) begin
         window.push_back($countones(bits));
         if (window.size() == BEATS) begin
            s = 0;
            foreach (window[k]) s += window[k];
            expSum = s;
            expAct = (s >= THRESH);
            window.delete();
            resultPending = 1'b1;
         end
      end
   endtask

   task automatic checkModel();
      checkOutput("outValid", 32'(out_valid), 32'(resultPending));
      checkOutput("inReady", 32'(in_ready), 32'(!resultPending));
      checkOutput("beatCnt", 32'(beat_cnt), 32'(window.size()));
      checkOutput("outSum", 32'(out_sum), 32'(expSum));
      checkOutput("outAct", 32'(out_act), 32'(expAct));
   endtask

   // One clock: drive on the falling edge, advance the model at the rising edge, check just after.
   task automatic applyStimulus(input bit rstN, input bit clrV, input logic [DATA_W-1:0] bits,
                                input bit valid, input bit oready);
      @(negedge clk);
      rst_n     = rstN;
      clr       = clrV;
      in_bits   = bits;
      in_valid  = valid;
      out_ready = oready;
      @(posedge clk);
      modelEdge(rstN, clrV, bits, valid, oready);
      #1;
      checkModel();
   endtask

   task automatic runWindow(input logic [DATA_W-1:0] bits, input int sumWant, input bit actWant);
      for (int i = 0; i < BEATS; i++) applyStimulus(1'b1, 1'b0, bits, 1'b1, 1'b1);
      checkOutput("winValid", 32'(out_valid), 32'd1);
      checkOutput("winSum", 32'(out_sum), 32'(sumWant));
      checkOutput("winAct", 32'(out_act), 32'(actWant));
      applyStimulus(1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);
      checkOutput("winDrained", 32'(out_valid), 32'd0);
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'hFF, 1'b1, 1'b1);
      checkOutput("rstValid", 32'(out_valid), 32'd0);
      checkOutput("rstSum", 32'(out_sum), 32'd0);
      checkOutput("rstBeat", 32'(beat_cnt), 32'd0);
      checkOutput("rstReady", 32'(in_ready), 32'd1);

      runWindow(8'hFF, 72, 1'b1);
      runWindow(8'h0F, 36, 1'b1);
      runWindow(8'h07, 27, 1'b0);

      // Backpressure: result must hold and offered beats must not be counted.
      for (int i = 0; i < BEATS; i++) applyStimulus(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
         checkOutput("bpValid", 32'(out_valid), 32'd1);
         checkOutput("bpSum", 32'(out_sum), 32'd72);
         checkOutput("bpReady", 32'(in_ready), 32'd0);
         checkOutput("bpBeat", 32'(beat_cnt), 32'd0);
      end
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("bpRelease", 32'(in_ready), 32'd1);

      // Gapped input with garbage on in_bits while in_valid is low.
      for (int i = 0; i < 2 * BEATS - 1; i++) begin
         if (i % 2 == 0) applyStimulus(1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
         else            applyStimulus(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
      end
      checkOutput("gapSum", 32'(out_sum), 32'd9);
      checkOutput("gapValid", 32'(out_valid), 32'd1);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

      // Flush partway through a window, with a dropped coincident beat.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
      checkOutput("clrBeat", 32'(beat_cnt), 32'd0);
      runWindow(8'h01, 9, 1'b0);

      // Flush coincident with the final beat suppresses the result.
      for (int i = 0; i < BEATS - 1; i++) applyStimulus(1'b1, 1'b0, 8'h01, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 8'h01, 1'b1, 1'b1);
      checkOutput("clrLastValid", 32'(out_valid), 32'd0);
      checkOutput("clrLastBeat", 32'(beat_cnt), 32'd0);

      // Flush while a result is waiting voids the transfer.
      for (int i = 0; i < BEATS; i++) applyStimulus(1'b1, 1'b0, 8'h03, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
      checkOutput("clrOutValid", 32'(out_valid), 32'd0);
      checkOutput("clrOutSum", 32'(out_sum), 32'd18);

      // Reset mid-window.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'hFF, 1'b1, 1'b1);
      runWindow(8'h03, 18, 1'b0);

      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 199) != 0),
                       ($urandom_range(0, 49) == 0),
                       DATA_W'($urandom),
                       ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 1) == 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
